// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one unified word-addressed memory, 2-5 cycles per instruction.
//   state | meaning
//   IF    | ir <= mem[pc], pc += 4
//   ID    | latch rs/rt into a/b, form branch target, complete j/jal/jr/jalr
//   EX    | ALU operation, resolve beq/bne
//   MEM   | lw reads into mdr, sw writes memory
//   WB    | write rd (R-type) or rt (I-type, lw)
module multi_cycle_cpu #(
  parameter int    MEM_WORDS = 256,
  parameter string INIT_FILE = "program.hex"
) (
  input logic reset,
  input logic clk
);
  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI   = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_ADD = 6'h20,
                         FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23,
                         FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26,
                         FN_NOR  = 6'h27, FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  state_t      state, state_nx;
  logic [31:0] pc, ir, a, b, target, alu_out, mdr, alu_res;
  logic [31:0] mem [0:MEM_WORDS-1];
  logic [31:0] reg_file [0:31];

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt, wb_dst;
  logic [31:0]   simm, zimm, rs_val, rt_val;
  logic [AW-1:0] pc_idx, data_idx;
  logic          is_ralu, is_ialu, is_lw, is_sw, is_br, is_j, is_jal, is_jr, is_jalr;
  logic          is_jump, is_known, br_taken;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign simm     = {{16{ir[15]}}, ir[15:0]};
  assign zimm     = {16'd0, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? 32'd0 : reg_file[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : reg_file[rt];
  // Index wraps modulo MEM_WORDS (power of two); the low two address bits are ignored.
  assign pc_idx   = pc[AW+1:2];
  assign data_idx = alu_out[AW+1:2];

  always_comb begin
    is_ralu = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_ralu = 1'b1;
        FN_JR:   is_jr   = 1'b1;
        FN_JALR: is_jalr = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_ialu  = opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI};
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jump  = is_j || is_jal || is_jr || is_jalr;
  assign is_known = is_ralu || is_ialu || is_lw || is_sw || is_br;
  assign wb_dst   = (opcode == OP_RTYPE) ? rd : rt;
  assign br_taken = (a == b) ^ (opcode == OP_BNE);

  always_comb begin
    alu_res = 32'd0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SLL:          alu_res = b << shamt;
        FN_SRL:          alu_res = b >> shamt;
        FN_SRA:          alu_res = $unsigned($signed(b) >>> shamt);
        FN_ADD, FN_ADDU: alu_res = a + b;
        FN_SUB, FN_SUBU: alu_res = a - b;
        FN_AND:          alu_res = a & b;
        FN_OR:           alu_res = a | b;
        FN_XOR:          alu_res = a ^ b;
        FN_NOR:          alu_res = ~(a | b);
        FN_SLT:          alu_res = {31'd0, $signed(a) < $signed(b)};
        FN_SLTU:         alu_res = {31'd0, a < b};
        default:         alu_res = 32'd0;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_res = a + simm;
        OP_SLTI:  alu_res = {31'd0, $signed(a) < $signed(simm)};
        OP_SLTIU: alu_res = {31'd0, a < simm};
        OP_ANDI:  alu_res = a & zimm;
        OP_ORI:   alu_res = a | zimm;
        OP_LUI:   alu_res = {ir[15:0], 16'd0};
        default:  alu_res = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IF:  state_nx = S_ID;
      // Jumps and unrecognised encodings finish in ID.
      S_ID:  state_nx = (is_jump || !is_known) ? S_IF : S_EX;
      S_EX: begin
        if (is_br)               state_nx = S_IF;
        else if (is_lw || is_sw) state_nx = S_MEM;
        else                     state_nx = S_WB;
      end
      S_MEM: state_nx = is_lw ? S_WB : S_IF;
      S_WB:  state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= 32'd0;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      target  <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      for (int i = 0; i < 32; i++) reg_file[i] <= 32'd0;
    end else begin
      case (state)
        S_IF: begin
          ir <= mem[pc_idx];
          pc <= pc + 32'd4;
        end
        S_ID: begin
          a      <= rs_val;
          b      <= rt_val;
          target <= pc + {simm[29:0], 2'b00};
          if (is_j || is_jal) pc <= {pc[31:28], ir[25:0], 2'b00};
          if (is_jal) reg_file[31] <= pc;
          if (is_jr || is_jalr) pc <= rs_val;
          if (is_jalr && (rd != 5'd0)) reg_file[rd] <= pc;
        end
        S_EX: begin
          alu_out <= alu_res;
          if (is_br && br_taken) pc <= target;
        end
        S_MEM: begin
          if (is_lw) mdr <= mem[data_idx];
        end
        S_WB: begin
          if (wb_dst != 5'd0) reg_file[wb_dst] <= is_lw ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset; an asserted reset forces state to IF, so an aborted sw never writes.
  always_ff @(posedge clk) begin
    if ((state == S_MEM) && is_sw) mem[data_idx] <= b;
  end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Directed and random programs for multi_cycle_cpu, checked against an instruction-level model.
module tb_multi_cycle_cpu;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;

  int rfn [13] = '{0, 2, 3, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int iop [7]  = '{8, 9, 10, 11, 12, 13, 15};

  multi_cycle_cpu #(.MEM_WORDS(256), .INIT_FILE("")) dut (.reset(reset), .clk(clk));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input logic [31:0] addr);
    return {6'(op), addr[27:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.mem[idx] = w;
    m_mem[idx]   = w;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Executes one instruction architecturally and returns the cycles it should take.
  task automatic model_step(output int cyc);
    logic [31:0] w, a, b, simm, zimm, addr;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    w  = m_mem[m_pc[9:2]];
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
    a = m_reg[rs]; b = m_reg[rt];
    simm = {{16{w[15]}}, w[15:0]};
    zimm = {16'd0, w[15:0]};
    m_pc = m_pc + 32'd4;
    cyc  = 2;
    case (op)
      6'h00: begin
        cyc = 4;
        case (fn)
          6'h00: wr(rd, b << sh);
          6'h02: wr(rd, b >> sh);
          6'h03: wr(rd, $signed(b) >>> sh);
          6'h20, 6'h21: wr(rd, a + b);
          6'h22, 6'h23: wr(rd, a - b);
          6'h24: wr(rd, a & b);
          6'h25: wr(rd, a | b);
          6'h26: wr(rd, a ^ b);
          6'h27: wr(rd, ~(a | b));
          6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h2B: wr(rd, (a < b) ? 32'd1 : 32'd0);
          6'h08: begin m_pc = a; cyc = 2; end
          6'h09: begin wr(rd, m_pc); m_pc = a; cyc = 2; end
          default: cyc = 2;
        endcase
      end
      6'h02: m_pc = {m_pc[31:28], w[25:0], 2'b00};
      6'h03: begin wr(5'd31, m_pc); m_pc = {m_pc[31:28], w[25:0], 2'b00}; end
      6'h04: begin cyc = 3; if (a == b) m_pc = m_pc + (simm << 2); end
      6'h05: begin cyc = 3; if (a != b) m_pc = m_pc + (simm << 2); end
      6'h08, 6'h09: begin cyc = 4; wr(rt, a + simm); end
      6'h0A: begin cyc = 4; wr(rt, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0); end
      6'h0B: begin cyc = 4; wr(rt, (a < simm) ? 32'd1 : 32'd0); end
      6'h0C: begin cyc = 4; wr(rt, a & zimm); end
      6'h0D: begin cyc = 4; wr(rt, a | zimm); end
      6'h0F: begin cyc = 4; wr(rt, {w[15:0], 16'd0}); end
      6'h23: begin cyc = 5; addr = a + simm; wr(rt, m_mem[addr[9:2]]); end
      6'h2B: begin cyc = 4; addr = a + simm; m_mem[addr[9:2]] = b; end
      default: cyc = 2;
    endcase
  endtask

  task automatic run_steps(input int n, input int already);
    int total, c;
    total = 0;
    for (int i = 0; i < n; i++) begin
      model_step(c);
      total += c;
    end
    repeat (total - already) @(posedge clk);
    #1;
  endtask

  task automatic run_to(input logic [31:0] end_pc);
    int total, c, steps;
    total = 0;
    steps = 0;
    while ((m_pc != end_pc) && (steps < 500)) begin
      model_step(c);
      total += c;
      steps++;
    end
    repeat (total) @(posedge clk);
    #1;
  endtask

  task automatic begin_prog();
    reset = 1'b0;
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    for (int i = 0; i < 256; i++) put(i, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic compare_all(input string tag, input int lo, input int hi);
    chk({tag, "_pc"}, dut.pc, m_pc);
    chk({tag, "_state"}, 32'(dut.state), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), dut.reg_file[i], m_reg[i]);
    for (int i = lo; i <= hi; i++) chk($sformatf("%s_m%0d", tag, i), dut.mem[i], m_mem[i]);
  endtask

  initial begin
    int c, n, kind, off, kk, maxoff;
    logic [31:0] w;

    // Reset, first fetch, ALU chain (28 cycles)
    begin_prog();
    put(0, enc_i(8, 0, 1, 5));
    put(1, enc_i(8, 0, 2, -3));
    put(2, enc_r(32, 1, 2, 3, 0));
    put(3, enc_r(42, 2, 1, 4, 0));
    put(4, enc_r(43, 2, 1, 5, 0));
    put(5, enc_i(15, 0, 6, 'h1234));
    put(6, enc_i(13, 6, 6, 'h5678));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", dut.pc, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_ir", dut.ir, 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_r%0d", i), dut.reg_file[i], 32'd0);
    release_reset();
    @(posedge clk);
    #1;
    chk("first_pc", dut.pc, 32'd4);
    chk("first_state", 32'(dut.state), 32'd1);
    chk("first_ir", dut.ir, enc_i(8, 0, 1, 5));
    run_steps(7, 1);
    chk("alu_pc28", dut.pc, 32'd28);
    chk("alu_r3", dut.reg_file[3], 32'd2);
    chk("alu_r4", dut.reg_file[4], 32'd1);
    chk("alu_r5", dut.reg_file[5], 32'd0);
    chk("alu_r6", dut.reg_file[6], 32'h12345678);
    compare_all("alu", 0, -1);

    // sw/lw round trip; lw takes 5 cycles
    begin_prog();
    put(0, enc_i(8, 0, 1, 'h40));
    put(1, enc_i(8, 0, 2, 'h7F));
    put(2, enc_i(43, 1, 2, 4));
    put(3, enc_i(35, 1, 3, 4));
    release_reset();
    run_steps(3, 0);
    chk("sw_m17", dut.mem[17], 32'h7F);
    repeat (4) @(posedge clk);
    #1;
    chk("lw_in_wb", 32'(dut.state), 32'd4);
    chk("lw_r3_pending", dut.reg_file[3], 32'd0);
    model_step(c);
    repeat (c - 4) @(posedge clk);
    #1;
    chk("lw_r3", dut.reg_file[3], 32'h7F);
    compare_all("mem", 16, 18);

    // Branches and jumps
    begin_prog();
    put(0, enc_i(4, 0, 0, 1));
    put(1, enc_i(8, 0, 7, 1));
    put(2, enc_j(3, 32'h40));
    put(3, enc_i(8, 0, 8, 2));
    put(4, enc_i(5, 8, 8, 5));
    put(5, enc_i(8, 0, 10, 'h50));
    put(6, enc_r(9, 10, 0, 11, 0));
    put(16, enc_i(8, 0, 9, 3));
    put(17, enc_r(8, 31, 0, 0, 0));
    put(20, enc_i(8, 0, 12, 4));
    put(21, enc_j(2, 32'h5C));
    put(22, enc_i(8, 0, 7, 9));
    release_reset();
    run_steps(1, 0);
    chk("beq_pc", dut.pc, 32'd8);
    chk("beq_state", 32'(dut.state), 32'd0);
    run_to(32'h5C);
    chk("br_r7", dut.reg_file[7], 32'd0);
    chk("jal_r31", dut.reg_file[31], 32'd12);
    chk("jalr_r11", dut.reg_file[11], 32'd28);
    chk("br_pc", dut.pc, 32'h5C);
    compare_all("br", 0, -1);

    // $0 protection and arithmetic shift
    begin_prog();
    put(0, enc_i(8, 0, 0, 9));
    put(1, enc_i(15, 0, 1, 'h8000));
    put(2, enc_r(3, 0, 1, 2, 4));
    release_reset();
    run_steps(3, 0);
    chk("zero_r0", dut.reg_file[0], 32'd0);
    chk("sra_r2", dut.reg_file[2], 32'hF8000000);
    compare_all("sra", 0, -1);

    // Asynchronous reset during lw MEM
    begin_prog();
    put(16, 32'hABCD);
    put(0, enc_i(8, 0, 1, 'h40));
    put(1, enc_i(8, 0, 3, 'h55));
    put(2, enc_i(35, 1, 3, 0));
    release_reset();
    repeat (11) @(posedge clk);
    #1;
    chk("lwab_state_mem", 32'(dut.state), 32'd3);
    chk("lwab_r3_before", dut.reg_file[3], 32'h55);
    #2;
    reset = 1'b0;
    #1;
    chk("lwab_pc_async", dut.pc, 32'd0);
    chk("lwab_state_async", 32'(dut.state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("lwab_r3", dut.reg_file[3], 32'd0);
    chk("lwab_ir", dut.ir, 32'd0);

    // Asynchronous reset during sw MEM
    begin_prog();
    put(16, 32'hABCD);
    put(0, enc_i(8, 0, 1, 'h40));
    put(1, enc_i(8, 0, 2, 'h33));
    put(2, enc_i(43, 1, 2, 0));
    release_reset();
    repeat (11) @(posedge clk);
    #1;
    chk("swab_state_mem", 32'(dut.state), 32'd3);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("swab_m16", dut.mem[16], 32'hABCD);

    // Random programs: seeded registers then mixed ALU/load/store/forward-branch/unknown ops
    for (int it = 0; it < 4; it++) begin
      begin_prog();
      for (int i = 128; i < 256; i++) put(i, $urandom);
      n = 0;
      for (int k = 1; k < 8; k++) begin
        put(n, enc_i(15, 0, k, int'($urandom_range(0, 65535)))); n++;
        put(n, enc_i(13, k, k, int'($urandom_range(0, 65535)))); n++;
      end
      for (int s = 0; s < 22; s++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 3) begin
          w = enc_r(rfn[$urandom_range(0, 12)], $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 31));
        end else if (kind <= 5) begin
          w = enc_i(iop[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 65535));
        end else if (kind <= 7) begin
          kk  = $urandom_range(128, 255);
          off = kk * 4 + int'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) off = off - 1024;
          w = enc_i((kind == 6) ? 35 : 43, 0, $urandom_range(0, 7), off);
        end else if (kind == 8) begin
          maxoff = 36 - (n + 1);
          if (maxoff > 2) maxoff = 2;
          w = enc_i(($urandom_range(0, 1) == 1) ? 5 : 4, $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, maxoff));
        end else begin
          w = $urandom;
          w[31:26] = 6'h3F;
        end
        put(n, w);
        n++;
      end
      release_reset();
      run_to(32'(n * 4));
      compare_all($sformatf("rnd%0d", it), 128, 255);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
